// File: rtl/fact_pkg.sv
// Shared definitions for the sequential factorial engine.
//   fact_state_t : controller states (IDLE, CALC, DONE)
//   DEF_N_W      : default operand width
//   CNT_W        : iteration counter width for the default operand width
//   fact_max_n() : largest n whose factorial still fits in res_w bits
package fact_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fact_state_t;

    localparam int DEF_N_W = 4;

    // One bit wider than the operand so the counter can step past 2**N_W-1.
    localparam int CNT_W = DEF_N_W + 1;

    // Largest n with n! < 2**res_w. Valid for res_w up to 62.
    function automatic int fact_max_n(input int res_w);
        longint unsigned prod;
        longint unsigned limit;
        int k;
        prod  = 64'd1;
        limit = 64'd1 << res_w;
        k     = 1;
        while ((k < 20) && ((prod * longint'(k + 1)) < limit)) begin
            k    = k + 1;
            prod = prod * longint'(k);
        end
        return k;
    endfunction

endpackage

// File: rtl/fact_mul_sat.sv
// Combinational saturating multiply step for the factorial engine.
//   acc    : running product (RES_W bits)
//   i      : current multiplier (I_W bits)
//   sat_in : an earlier step already overflowed
//   prod   : acc*i, forced to all-ones when ovf is set
//   ovf    : product does not fit in RES_W bits, or sat_in was set
module fact_mul_sat #(
    parameter int RES_W = 32,
    parameter int I_W   = 5
) (
    input  logic [RES_W-1:0] acc,
    input  logic [I_W-1:0]   i,
    input  logic             sat_in,
    output logic [RES_W-1:0] prod,
    output logic             ovf
);

    logic [RES_W+I_W-1:0] full;

    // Both operands are widened to the full product width so nothing is lost.
    assign full = {{I_W{1'b0}}, acc} * {{RES_W{1'b0}}, i};

    // Once saturated the engine stays saturated, even if later bits would look clean.
    assign ovf  = sat_in | (|full[RES_W+I_W-1:RES_W]);
    assign prod = ovf ? {RES_W{1'b1}} : full[RES_W-1:0];

endmodule

// File: rtl/factorial_seq_unit.sv
// Multi-cycle factorial engine, one multiply per clock.
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset
//   start    : request, accepted only while ready is high
//   n        : operand, captured on the accepting edge
//   ready    : high in IDLE and DONE
//   busy     : high in CALC
//   done     : one-cycle pulse, result/overflow valid from this cycle
//   result   : n!, all-ones on overflow, held until the next done
//   overflow : n! did not fit in RES_W bits, held with result
module factorial_seq_unit
    import fact_pkg::*;
#(
    parameter int N_W   = 4,
    parameter int RES_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N_W-1:0]   n,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] result,
    output logic             overflow
);

    // The counter is one bit wider than n so the largest operand ends cleanly.
    localparam int CW = N_W + 1;

    fact_state_t      state;
    fact_state_t      state_next;
    logic [N_W-1:0]   n_lat;
    logic [CW-1:0]    i;
    logic [RES_W-1:0] acc;
    logic             sat;
    logic [RES_W-1:0] mul_prod;
    logic             mul_ovf;
    logic             accept;
    logic             finish;

    fact_mul_sat #(
        .RES_W (RES_W),
        .I_W   (CW)
    ) u_mul (
        .acc    (acc),
        .i      (i),
        .sat_in (sat),
        .prod   (mul_prod),
        .ovf    (mul_ovf)
    );

    assign accept = start && (state != CALC);

    // The loop ends once i has passed n, which also covers 0! and 1! in one cycle.
    assign finish = (state == CALC) && (i > {1'b0, n_lat});

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; handshake outputs decode from the state register only.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (finish) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) begin
                    state_next = CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. The multiply keeps running after saturation so the latency
    // depends only on n.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_lat    <= '0;
            i        <= '0;
            acc      <= '0;
            sat      <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            n_lat <= n;
            i     <= CW'(2);
            acc   <= RES_W'(1);
            sat   <= 1'b0;
        end else if (state == CALC) begin
            if (finish) begin
                result   <= acc;
                overflow <= sat;
            end else begin
                acc <= mul_prod;
                sat <= mul_ovf;
                i   <= i + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_factorial_seq_unit.sv
// Self-checking bench for factorial_seq_unit: a table of directed vectors,
// hand-written corner sequences, and random requests against a plain
// arithmetic factorial model.
module tb_factorial_seq_unit;
    import fact_pkg::*;

    localparam int N_W   = 4;
    localparam int RES_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [N_W-1:0]   n;
    logic             ready;
    logic             busy;
    logic             done;
    logic [RES_W-1:0] result;
    logic             overflow;

    int checks = 0;
    int errors = 0;
    longint unsigned lastRes;
    longint unsigned lastOvf;

    typedef struct {
        int              nv;
        longint unsigned expRes;
        bit              expOvf;
        int              expLat;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    factorial_seq_unit #(
        .N_W   (N_W),
        .RES_W (RES_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .n        (n),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    task automatic checkOutput(input string name, input longint unsigned act,
                               input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain factorial in 64-bit arithmetic, then saturate.
    function automatic void modelFact(input int nv, output longint unsigned r, output bit o);
        longint unsigned f;
        f = 64'd1;
        for (int k = 2; k <= nv; k++) begin
            f = f * longint'(k);
        end
        if (f >= (64'd1 << RES_W)) begin
            r = (64'd1 << RES_W) - 64'd1;
            o = 1'b1;
        end else begin
            r = f;
            o = 1'b0;
        end
    endfunction

    // Issues one request from a ready cycle and waits for done. Optionally
    // pulses start with another operand at CALC cycle pulseAt.
    task automatic applyStimulus(input int nv, input int pulseAt, input int pulseN,
                                 output int lat);
        start = 1'b1;
        n     = N_W'(nv);
        step();
        start = 1'b0;
        n     = ~n;
        lat   = 1;
        while (!done && lat < 64) begin
            checkOutput("busy_in_calc", busy, 1);
            checkOutput("ready_in_calc", ready, 0);
            checkOutput("result_held", result, lastRes);
            checkOutput("overflow_held", overflow, lastOvf);
            if (lat == pulseAt) begin
                start = 1'b1;
                n     = N_W'(pulseN);
            end else begin
                start = 1'b0;
            end
            step();
            lat++;
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: no done for n=%0d after %0d cycles", nv, lat);
        end
    endtask

    task automatic runCheck(input int nv, input int pulseAt, input int pulseN,
                            input longint unsigned expRes, input bit expOvf, input int expLat);
        int lat;
        applyStimulus(nv, pulseAt, pulseN, lat);
        checkOutput($sformatf("latency_n%0d", nv), longint'(lat), longint'(expLat));
        checkOutput($sformatf("result_n%0d", nv), result, expRes);
        checkOutput($sformatf("overflow_n%0d", nv), overflow, expOvf);
        checkOutput("ready_in_done", ready, 1);
        checkOutput("busy_in_done", busy, 0);
        lastRes = expRes;
        lastOvf = expOvf;
    endtask

    task automatic idleGap();
        step();
        checkOutput("done_single_cycle", done, 0);
        checkOutput("ready_idle", ready, 1);
        checkOutput("result_kept_idle", result, lastRes);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int nv;
        int maxN;
        longint unsigned mr;
        bit mo;

        vecs[0] = '{nv: 0,  expRes: 64'd1,          expOvf: 1'b0, expLat: 2};
        vecs[1] = '{nv: 1,  expRes: 64'd1,          expOvf: 1'b0, expLat: 2};
        vecs[2] = '{nv: 5,  expRes: 64'd120,        expOvf: 1'b0, expLat: 6};
        vecs[3] = '{nv: 12, expRes: 64'd479001600,  expOvf: 1'b0, expLat: 13};
        vecs[4] = '{nv: 13, expRes: 64'hFFFF_FFFF,  expOvf: 1'b1, expLat: 14};
        vecs[5] = '{nv: 15, expRes: 64'hFFFF_FFFF,  expOvf: 1'b1, expLat: 16};
        vecs[6] = '{nv: 3,  expRes: 64'd6,          expOvf: 1'b0, expLat: 4};
        vecs[7] = '{nv: 2,  expRes: 64'd2,          expOvf: 1'b0, expLat: 3};

        reset = 1'b1;
        start = 1'b1;
        n     = '1;
        step();
        step();
        checkOutput("reset_ready", ready, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_overflow", overflow, 0);
        reset   = 1'b0;
        start   = 1'b0;
        lastRes = 0;
        lastOvf = 0;

        for (int v = 0; v < 8; v++) begin
            runCheck(vecs[v].nv, -1, 0, vecs[v].expRes, vecs[v].expOvf, vecs[v].expLat);
            idleGap();
        end

        $display("[TB] start pulsed mid-CALC");
        runCheck(7, 3, 2, 64'd5040, 1'b0, 8);
        idleGap();

        $display("[TB] back-to-back request from DONE");
        runCheck(6, -1, 0, 64'd720, 1'b0, 7);
        runCheck(4, -1, 0, 64'd24, 1'b0, 5);
        idleGap();

        $display("[TB] reset during CALC");
        start = 1'b1;
        n     = 4'd9;
        step();
        start = 1'b0;
        step();
        step();
        checkOutput("pre_reset_busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("abort_ready", ready, 1);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_result", result, 0);
        checkOutput("abort_overflow", overflow, 0);
        lastRes = 0;
        lastOvf = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            checkOutput("no_done_after_abort", done, 0);
        end
        runCheck(4, -1, 0, 64'd24, 1'b0, 5);
        idleGap();

        $display("[TB] random requests");
        maxN = fact_max_n(RES_W);
        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                nv = maxN + int'($urandom_range(0, 1));
            end else begin
                nv = int'($urandom_range(0, 15));
            end
            modelFact(nv, mr, mo);
            runCheck(nv, -1, 0, mr, mo, ((nv > 1) ? nv : 1) + 1);
            if ($urandom_range(0, 1) == 1) begin
                idleGap();
            end
        end
        idleGap();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
